// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - op codes, FSM state and latency lookup shared by the FP issue controller
package fpu_pkg;

    localparam logic [2:0] FPU_ADD  = 3'd0;
    localparam logic [2:0] FPU_MIN  = 3'd1;
    localparam logic [2:0] FPU_MUL  = 3'd2;
    localparam logic [2:0] FPU_DIV  = 3'd3;
    localparam logic [2:0] FPU_XORI = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } fpu_state_t;

    function automatic logic op_valid(input logic [2:0] op);
        return op <= FPU_XORI;
    endfunction

    // Counter preload: the last EXEC cycle is the one where cnt reaches zero.
    function automatic logic [3:0] lat_of(
        input logic [2:0] op,
        input logic [3:0] l_add,
        input logic [3:0] l_min,
        input logic [3:0] l_mul,
        input logic [3:0] l_div,
        input logic [3:0] l_xori
    );
        case (op)
            FPU_ADD:  return l_add - 4'd1;
            FPU_MIN:  return l_min - 4'd1;
            FPU_MUL:  return l_mul - 4'd1;
            FPU_DIV:  return l_div - 4'd1;
            FPU_XORI: return l_xori - 4'd1;
            default:  return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/fpu_flag_decode.sv
// rtl/fpu_flag_decode.sv - classifies a single-precision word into {nan, inf, zero, neg}
module fpu_flag_decode (
    input  logic [31:0] value,
    output logic [3:0]  flags
);
    logic       exp_ones;
    logic       exp_zero;
    logic       man_zero;

    assign exp_ones = (value[30:23] == 8'hFF);
    assign exp_zero = (value[30:23] == 8'h00);
    assign man_zero = (value[22:0] == 23'd0);

    assign flags = {exp_ones & ~man_zero, exp_ones & man_zero, exp_zero & man_zero, value[31]};

endmodule

// File: rtl/fpu_issue_ctrl.sv
// rtl/fpu_issue_ctrl.sv - multicycle issue/capture sequencer for the FP ALU; FPU_ISSUE_FLAGS_EN adds res_flags
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int unsigned LAT_ADD  = 2,
    parameter int unsigned LAT_MIN  = 1,
    parameter int unsigned LAT_MUL  = 3,
    parameter int unsigned LAT_DIV  = 6,
    parameter int unsigned LAT_XORI = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic [2:0]  fpu_sel,
    input  logic [31:0] fpu_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_err
`ifdef FPU_ISSUE_FLAGS_EN
    ,
    output logic [3:0]  res_flags
`endif
);

    fpu_state_t  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] fpu_a_q, fpu_a_d;
    logic [31:0] fpu_b_q, fpu_b_d;
    logic [2:0]  fpu_sel_q, fpu_sel_d;
    logic [31:0] res_data_q, res_data_d;
    logic        res_err_q, res_err_d;

`ifdef FPU_ISSUE_FLAGS_EN
    logic [3:0]  res_flags_q, res_flags_d;
    logic [3:0]  alu_flags;

    fpu_flag_decode u_flag_decode (
        .value (fpu_out),
        .flags (alu_flags)
    );

    assign res_flags = res_flags_q;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fpu_a_d    = fpu_a_q;
        fpu_b_d    = fpu_b_q;
        fpu_sel_d  = fpu_sel_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
`ifdef FPU_ISSUE_FLAGS_EN
        res_flags_d = res_flags_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    fpu_a_d   = req_a;
                    fpu_b_d   = req_b;
                    fpu_sel_d = req_op;
                    if (op_valid(req_op)) begin
                        cnt_d   = lat_of(req_op, 4'(LAT_ADD), 4'(LAT_MIN), 4'(LAT_MUL),
                                         4'(LAT_DIV), 4'(LAT_XORI));
                        state_d = EXEC;
                    end else begin
                        res_data_d = 32'd0;
                        res_err_d  = 1'b1;
`ifdef FPU_ISSUE_FLAGS_EN
                        res_flags_d = 4'd0;
`endif
                        state_d    = DONE;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    res_data_d = fpu_out;
                    res_err_d  = 1'b0;
`ifdef FPU_ISSUE_FLAGS_EN
                    res_flags_d = (fpu_sel_q == FPU_XORI) ? 4'd0 : alu_flags;
`endif
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            fpu_a_q    <= 32'd0;
            fpu_b_q    <= 32'd0;
            fpu_sel_q  <= 3'd0;
            res_data_q <= 32'd0;
            res_err_q  <= 1'b0;
`ifdef FPU_ISSUE_FLAGS_EN
            res_flags_q <= 4'd0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fpu_a_q    <= fpu_a_d;
            fpu_b_q    <= fpu_b_d;
            fpu_sel_q  <= fpu_sel_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
`ifdef FPU_ISSUE_FLAGS_EN
            res_flags_q <= res_flags_d;
`endif
        end
    end

    assign req_ready = (state_q == IDLE);
    assign res_valid = (state_q == DONE);
    assign fpu_a     = fpu_a_q;
    assign fpu_b     = fpu_b_q;
    assign fpu_sel   = fpu_sel_q;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb/tb_fpu_issue_ctrl.sv - transaction-level check of fpu_issue_ctrl against a latency/ALU model
module tb_fpu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic [2:0]  fpu_sel;
    logic [31:0] fpu_out;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_err;
`ifdef FPU_ISSUE_FLAGS_EN
    logic [3:0]  res_flags;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fpu_issue_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .fpu_a     (fpu_a),
        .fpu_b     (fpu_b),
        .fpu_sel   (fpu_sel),
        .fpu_out   (fpu_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err)
`ifdef FPU_ISSUE_FLAGS_EN
        ,
        .res_flags (res_flags)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [2:0] op);
        case (op)
            3'd0:    return 2;
            3'd1:    return 1;
            3'd2:    return 3;
            3'd3:    return 6;
            3'd4:    return 1;
            default: return 0;
        endcase
    endfunction

    // Stand-in ALU: exact answers for the directed vectors, a deterministic mix otherwise.
    function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 3'd4) return a ^ b;
        if (op == 3'd0 && a == 32'h3FC00000 && b == 32'h40100000) return 32'h40700000;
        if (op == 3'd3 && a == 32'h3F800000 && b == 32'h40800000) return 32'h3E800000;
        if (op == 3'd2 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        if (op == 3'd2 && a == 32'h7F800000 && b == 32'h40000000) return 32'h7F800000;
        return (a * 32'h9E3779B1) ^ {b[15:0], b[31:16]} ^ {29'd0, op};
    endfunction

    function automatic logic [3:0] exp_flags(input logic [2:0] op, input logic [31:0] v);
        logic [7:0]  e;
        logic [22:0] m;
        e = v[30:23];
        m = v[22:0];
        if (op > 3'd3) return 4'd0;
        return {(e == 8'd255) && (m != 0), (e == 8'd255) && (m == 0), (e == 8'd0) && (m == 0), v[31]};
    endfunction

    task automatic junk_inputs();
        req_valid = 1'($urandom_range(0, 1));
        req_op    = 3'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
    endtask

    task automatic check_result(input string tag, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] d, input logic e);
        check_eq({tag, "_res_valid"}, 32'(res_valid), 32'd1);
        check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check_eq({tag, "_res_data"}, res_data, d);
        check_eq({tag, "_res_err"}, 32'(res_err), 32'(e));
        check_eq({tag, "_fpu_a"}, fpu_a, a);
        check_eq({tag, "_fpu_b"}, fpu_b, b);
        check_eq({tag, "_fpu_sel"}, 32'(fpu_sel), 32'(op));
`ifdef FPU_ISSUE_FLAGS_EN
        check_eq({tag, "_res_flags"}, 32'(res_flags), 32'(e ? 4'd0 : exp_flags(op, d)));
`endif
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int stall);
        int          lat;
        logic        inv;
        logic [31:0] exp_d;
        inv   = (op > 3'd4);
        lat   = exp_lat(op);
        exp_d = inv ? 32'd0 : alu(op, a, b);
        check_eq({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        fpu_out   = $urandom;
        @(negedge clk);
        for (int n = 0; n < lat; n++) begin
            junk_inputs();
            check_eq({tag, "_exec_fpu_a"}, fpu_a, a);
            check_eq({tag, "_exec_fpu_b"}, fpu_b, b);
            check_eq({tag, "_exec_fpu_sel"}, 32'(fpu_sel), 32'(op));
            check_eq({tag, "_exec_req_ready"}, 32'(req_ready), 32'd0);
            check_eq({tag, "_exec_res_valid"}, 32'(res_valid), 32'd0);
            fpu_out = (n == lat - 1) ? alu(op, a, b) : $urandom;
            @(negedge clk);
        end
        check_result({tag, "_done"}, op, a, b, exp_d, inv);
        for (int s = 0; s < stall; s++) begin
            res_ready = 1'b0;
            junk_inputs();
            fpu_out = $urandom;
            @(negedge clk);
            check_result({tag, "_stall"}, op, a, b, exp_d, inv);
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check_eq({tag, "_post_res_valid"}, 32'(res_valid), 32'd0);
        check_eq({tag, "_post_req_ready"}, 32'(req_ready), 32'd1);
        check_eq({tag, "_post_fpu_a"}, fpu_a, a);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check_eq({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check_eq({tag, "_res_data"}, res_data, 32'd0);
        check_eq({tag, "_res_err"}, 32'(res_err), 32'd0);
        check_eq({tag, "_fpu_a"}, fpu_a, 32'd0);
        check_eq({tag, "_fpu_b"}, fpu_b, 32'd0);
        check_eq({tag, "_fpu_sel"}, 32'(fpu_sel), 32'd0);
`ifdef FPU_ISSUE_FLAGS_EN
        check_eq({tag, "_res_flags"}, 32'(res_flags), 32'd0);
`endif
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_a     = 32'd0;
        req_b     = 32'd0;
        res_ready = 1'b0;
        fpu_out   = 32'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset");

        run_op("add", 3'd0, 32'h3FC00000, 32'h40100000, 0);
        run_op("div", 3'd3, 32'h3F800000, 32'h40800000, 1);
        run_op("mul_bp", 3'd2, 32'h40000000, 32'h40400000, 5);
        run_op("inv6", 3'd6, 32'h12345678, 32'h0, 2);
        run_op("min_after_inv", 3'd1, 32'h40000000, 32'hBF800000, 0);
        run_op("mul_inf", 3'd2, 32'h7F800000, 32'h40000000, 0);
        run_op("xori", 3'd4, 32'hFFFFFFFF, 32'h0, 1);

        // Reset on the third cycle of a divide must discard it entirely.
        req_valid = 1'b1;
        req_op    = 3'd3;
        req_a     = 32'h3F800000;
        req_b     = 32'h40800000;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("midop_rst");
        for (int i = 0; i < 8; i++) begin
            fpu_out = $urandom;
            @(negedge clk);
            check_eq("midop_no_stale_valid", 32'(res_valid), 32'd0);
        end

        for (int i = 0; i < 40; i++) begin
            run_op("rand", 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
